// File: rtl/mem_op_sequencer.sv
// In-order memory-op queue between 2-wide dispatch and the LSU, with CDB snooping of late operands.
// Optional MEMQ_CDB_BYPASS_EN: forward a same-cycle CDB hit on the head entry straight to the LSU outputs.
`timescale 1ns/1ps
module mem_op_sequencer #(
    parameter int DEPTH  = 8,
    parameter int XLEN   = 32,
    parameter int PHYS_W = 6,
    parameter int ROB_W  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    in_valid,
    input  logic [1:0]                    in_is_load,
    input  logic [1:0][7:0]               in_opcode,
    input  logic [1:0][XLEN-1:0]          in_base_val,
    input  logic [1:0][PHYS_W-1:0]        in_base_tag,
    input  logic [1:0]                    in_base_ready,
    input  logic [1:0][XLEN-1:0]          in_offset,
    input  logic [1:0][XLEN-1:0]          in_data_val,
    input  logic [1:0][PHYS_W-1:0]        in_data_tag,
    input  logic [1:0]                    in_data_ready,
    input  logic [1:0][PHYS_W-1:0]        in_phys_rd,
    input  logic [1:0][ROB_W-1:0]         in_rob_idx,
    output logic                          in_ready,
    input  logic                          flush,
    input  logic [1:0]                    cdb_valid,
    input  logic [1:0][PHYS_W-1:0]        cdb_tag,
    input  logic [1:0][XLEN-1:0]          cdb_value,
    output logic                          lsu_valid,
    input  logic                          lsu_ready,
    output logic                          lsu_is_load,
    output logic [7:0]                    lsu_opcode,
    output logic [XLEN-1:0]               lsu_base_addr,
    output logic [XLEN-1:0]               lsu_offset,
    output logic [PHYS_W-1:0]             lsu_phys_rd,
    output logic [ROB_W-1:0]              lsu_rob_idx,
    output logic [XLEN-1:0]               lsu_store_data_val,
    output logic                          lsu_store_data_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Handshakes: dispatch lanes are taken only in a cycle where in_ready is high (all-or-nothing,
    // ops must be held otherwise); the head transfers to the LSU on lsu_valid && lsu_ready, and
    // lsu_valid/fields stay put while lsu_ready is low apart from wakeup updates.

    logic                 e_is_load    [DEPTH];
    logic [7:0]           e_opcode     [DEPTH];
    logic [XLEN-1:0]      e_base_val   [DEPTH];
    logic [PHYS_W-1:0]    e_base_tag   [DEPTH];
    logic                 e_base_ready [DEPTH];
    logic [XLEN-1:0]      e_offset     [DEPTH];
    logic [XLEN-1:0]      e_data_val   [DEPTH];
    logic [PHYS_W-1:0]    e_data_tag   [DEPTH];
    logic                 e_data_ready [DEPTH];
    logic [PHYS_W-1:0]    e_phys_rd    [DEPTH];
    logic [ROB_W-1:0]     e_rob_idx    [DEPTH];

    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W-1:0]     rel_idx      [DEPTH];
    logic                 occupied     [DEPTH];
    logic [PTR_W-1:0]     lane_slot    [2];
    logic                 enq_fire;
    logic [CNT_W-1:0]     enq_n;
    logic                 deq;
    logic                 head_base_ready;

    function automatic logic snoop_hit(input logic [PHYS_W-1:0] tag);
        return (cdb_valid[0] && (cdb_tag[0] == tag)) || (cdb_valid[1] && (cdb_tag[1] == tag));
    endfunction

    // Port 1 takes precedence when both ports carry the tag.
    function automatic logic [XLEN-1:0] snoop_val(input logic [PHYS_W-1:0] tag);
        return (cdb_valid[1] && (cdb_tag[1] == tag)) ? cdb_value[1] : cdb_value[0];
    endfunction

    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign enq_fire = in_ready && (|in_valid) && !flush;
    assign enq_n    = enq_fire ? (CNT_W'(in_valid[0]) + CNT_W'(in_valid[1])) : '0;
    assign deq      = lsu_valid && lsu_ready;

    always_comb begin
        lane_slot[0] = tail;
        lane_slot[1] = in_valid[0] ? (tail + PTR_W'(1)) : tail;
        for (int i = 0; i < DEPTH; i++) begin
            rel_idx[i]  = PTR_W'(i) - head;
            occupied[i] = (CNT_W'(rel_idx[i]) < count);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_is_load[i]    <= 1'b0;
                e_opcode[i]     <= '0;
                e_base_val[i]   <= '0;
                e_base_tag[i]   <= '0;
                e_base_ready[i] <= 1'b0;
                e_offset[i]     <= '0;
                e_data_val[i]   <= '0;
                e_data_tag[i]   <= '0;
                e_data_ready[i] <= 1'b0;
                e_phys_rd[i]    <= '0;
                e_rob_idx[i]    <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_base_ready[i] <= 1'b0;
                e_data_ready[i] <= 1'b0;
            end
        end else begin
            // Wakeup only touches live entries so an empty queue keeps showing its stale head.
            for (int i = 0; i < DEPTH; i++) begin
                if (occupied[i] && !e_base_ready[i] && snoop_hit(e_base_tag[i])) begin
                    e_base_ready[i] <= 1'b1;
                    e_base_val[i]   <= snoop_val(e_base_tag[i]);
                end
                if (occupied[i] && !e_data_ready[i] && snoop_hit(e_data_tag[i])) begin
                    e_data_ready[i] <= 1'b1;
                    e_data_val[i]   <= snoop_val(e_data_tag[i]);
                end
            end
            // Enqueue targets free slots only, so it never collides with the wakeup writes above.
            for (int l = 0; l < 2; l++) begin
                if (enq_fire && in_valid[l]) begin
                    e_is_load[lane_slot[l]]    <= in_is_load[l];
                    e_opcode[lane_slot[l]]     <= in_opcode[l];
                    e_base_tag[lane_slot[l]]   <= in_base_tag[l];
                    e_base_ready[lane_slot[l]] <= in_base_ready[l] || snoop_hit(in_base_tag[l]);
                    e_base_val[lane_slot[l]]   <= (!in_base_ready[l] && snoop_hit(in_base_tag[l]))
                                                  ? snoop_val(in_base_tag[l]) : in_base_val[l];
                    e_offset[lane_slot[l]]     <= in_offset[l];
                    e_data_tag[lane_slot[l]]   <= in_data_tag[l];
                    e_data_ready[lane_slot[l]] <= in_data_ready[l] || snoop_hit(in_data_tag[l]);
                    e_data_val[lane_slot[l]]   <= (!in_data_ready[l] && snoop_hit(in_data_tag[l]))
                                                  ? snoop_val(in_data_tag[l]) : in_data_val[l];
                    e_phys_rd[lane_slot[l]]    <= in_phys_rd[l];
                    e_rob_idx[lane_slot[l]]    <= in_rob_idx[l];
                end
            end
            head  <= head + PTR_W'(deq);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + enq_n - CNT_W'(deq);
        end
    end

    always_comb begin
        lsu_is_load          = e_is_load[head];
        lsu_opcode           = e_opcode[head];
        lsu_offset           = e_offset[head];
        lsu_phys_rd          = e_phys_rd[head];
        lsu_rob_idx          = e_rob_idx[head];
        head_base_ready      = e_base_ready[head];
        lsu_base_addr        = e_base_val[head];
        lsu_store_data_ready = e_data_ready[head];
        lsu_store_data_val   = e_data_val[head];
`ifdef MEMQ_CDB_BYPASS_EN
        if (!e_base_ready[head] && snoop_hit(e_base_tag[head])) begin
            head_base_ready = 1'b1;
            lsu_base_addr   = snoop_val(e_base_tag[head]);
        end
        if (!e_data_ready[head] && snoop_hit(e_data_tag[head])) begin
            lsu_store_data_ready = 1'b1;
            lsu_store_data_val   = snoop_val(e_data_tag[head]);
        end
`endif
        lsu_valid = (count != '0) && head_base_ready && !flush;
    end

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Scoreboard bench for mem_op_sequencer: directed scenarios plus a randomized enqueue/issue phase.
`timescale 1ns/1ps
module tb_mem_op_sequencer;
  localparam int DEPTH  = 8;
  localparam int XLEN   = 32;
  localparam int PHYS_W = 6;
  localparam int ROB_W  = 6;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int E_W    = 1 + 8 + XLEN + XLEN + PHYS_W + ROB_W;

  logic                   clk;
  logic                   reset;
  logic [1:0]             in_valid;
  logic [1:0]             in_is_load;
  logic [1:0][7:0]        in_opcode;
  logic [1:0][XLEN-1:0]   in_base_val;
  logic [1:0][PHYS_W-1:0] in_base_tag;
  logic [1:0]             in_base_ready;
  logic [1:0][XLEN-1:0]   in_offset;
  logic [1:0][XLEN-1:0]   in_data_val;
  logic [1:0][PHYS_W-1:0] in_data_tag;
  logic [1:0]             in_data_ready;
  logic [1:0][PHYS_W-1:0] in_phys_rd;
  logic [1:0][ROB_W-1:0]  in_rob_idx;
  logic                   in_ready;
  logic                   flush;
  logic [1:0]             cdb_valid;
  logic [1:0][PHYS_W-1:0] cdb_tag;
  logic [1:0][XLEN-1:0]   cdb_value;
  logic                   lsu_valid;
  logic                   lsu_ready;
  logic                   lsu_is_load;
  logic [7:0]             lsu_opcode;
  logic [XLEN-1:0]        lsu_base_addr;
  logic [XLEN-1:0]        lsu_offset;
  logic [PHYS_W-1:0]      lsu_phys_rd;
  logic [ROB_W-1:0]       lsu_rob_idx;
  logic [XLEN-1:0]        lsu_store_data_val;
  logic                   lsu_store_data_ready;
  logic [CNT_W-1:0]       count;

  mem_op_sequencer #(.DEPTH(DEPTH), .XLEN(XLEN), .PHYS_W(PHYS_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_is_load(in_is_load), .in_opcode(in_opcode),
    .in_base_val(in_base_val), .in_base_tag(in_base_tag), .in_base_ready(in_base_ready),
    .in_offset(in_offset), .in_data_val(in_data_val), .in_data_tag(in_data_tag),
    .in_data_ready(in_data_ready), .in_phys_rd(in_phys_rd), .in_rob_idx(in_rob_idx),
    .in_ready(in_ready), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_is_load(lsu_is_load),
    .lsu_opcode(lsu_opcode), .lsu_base_addr(lsu_base_addr), .lsu_offset(lsu_offset),
    .lsu_phys_rd(lsu_phys_rd), .lsu_rob_idx(lsu_rob_idx),
    .lsu_store_data_val(lsu_store_data_val), .lsu_store_data_ready(lsu_store_data_ready),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] mon_exp;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] op_of(input logic [5:0] rob);
    return 8'h40 + {2'b00, rob};
  endfunction
  function automatic logic [31:0] off_of(input logic [5:0] rob);
    return {24'd0, rob, 2'b00};
  endfunction
  function automatic logic [5:0] phys_of(input logic [5:0] rob);
    return rob ^ 6'h15;
  endfunction

  task automatic push_exp(input logic ld, input logic [31:0] base, input logic [5:0] rob);
    exp_q.push_back({ld, op_of(rob), base, off_of(rob), phys_of(rob), rob});
  endtask

  // driver tasks
  task automatic clear_in();
    in_valid = '0; in_is_load = '0; in_opcode = '0; in_base_val = '0; in_base_tag = '0;
    in_base_ready = '0; in_offset = '0; in_data_val = '0; in_data_tag = '0; in_data_ready = '0;
    in_phys_rd = '0; in_rob_idx = '0; flush = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic drive_lane(input int l, input logic ld, input logic [31:0] base,
                            input logic [5:0] btag, input logic brdy, input logic [31:0] data,
                            input logic [5:0] dtag, input logic drdy, input logic [5:0] rob);
    in_valid[l]      = 1'b1;
    in_is_load[l]    = ld;
    in_opcode[l]     = op_of(rob);
    in_base_val[l]   = base;
    in_base_tag[l]   = btag;
    in_base_ready[l] = brdy;
    in_offset[l]     = off_of(rob);
    in_data_val[l]   = data;
    in_data_tag[l]   = dtag;
    in_data_ready[l] = drdy;
    in_phys_rd[l]    = phys_of(rob);
    in_rob_idx[l]    = rob;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  // scoreboard: every LSU handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && lsu_valid === 1'b1 && lsu_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_issue", 128'(lsu_valid), 128'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("issue", 128'({lsu_is_load, lsu_opcode, lsu_base_addr, lsu_offset,
                                lsu_phys_rd, lsu_rob_idx}), 128'(mon_exp));
      end
    end
  end

  int         mcount;
  logic [1:0] v;
  logic       acc;
  logic       deq_m;
  logic       ld;
  logic [31:0] b;
  logic [5:0] rob_ctr;

  initial begin
    clear_in();
    lsu_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 128'(lsu_valid), 128'(0));
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_count", 128'(count), 128'(0));
    check_eq("rst_fields", 128'({lsu_is_load, lsu_opcode, lsu_base_addr, lsu_offset, lsu_phys_rd,
                                 lsu_rob_idx, lsu_store_data_val, lsu_store_data_ready}), 128'(0));

    // reset then dual enqueue
    cyc(); lsu_ready = 1'b1;
    drive_lane(0, 1'b1, 32'h100, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd3);
    drive_lane(1, 1'b1, 32'h200, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd4);
    push_exp(1'b1, 32'h100, 6'd3); push_exp(1'b1, 32'h200, 6'd4);
    @(negedge clk); check_eq("t1_valid_T", 128'(lsu_valid), 128'(0));
    cyc(); @(negedge clk);
    check_eq("t1_valid_T1", 128'(lsu_valid), 128'(1));
    check_eq("t1_rob_T1", 128'(lsu_rob_idx), 128'(3));
    check_eq("t1_count_T1", 128'(count), 128'(2));
    cyc(); @(negedge clk);
    check_eq("t1_rob_T2", 128'(lsu_rob_idx), 128'(4));
    check_eq("t1_count_T2", 128'(count), 128'(1));
    cyc(); @(negedge clk);
    check_eq("t1_count_T3", 128'(count), 128'(0));
    check_eq("t1_valid_T3", 128'(lsu_valid), 128'(0));

    // fill to full, then drain
    for (int k = 0; k < 4; k++) begin
      cyc(); lsu_ready = 1'b0;
      drive_lane(0, 1'b1, 32'h1000 + 32'(k), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'(10 + 2*k));
      drive_lane(1, 1'b0, 32'h1100 + 32'(k), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'(11 + 2*k));
      push_exp(1'b1, 32'h1000 + 32'(k), 6'(10 + 2*k));
      push_exp(1'b0, 32'h1100 + 32'(k), 6'(11 + 2*k));
      @(negedge clk);
      check_eq("fill_count", 128'(count), 128'(2*k));
      check_eq("fill_in_ready", 128'(in_ready), 128'(1));
    end
    cyc();
    drive_lane(0, 1'b1, 32'hbad0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd60);
    drive_lane(1, 1'b1, 32'hbad1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd61);
    @(negedge clk);
    check_eq("full_count", 128'(count), 128'(8));
    check_eq("full_in_ready", 128'(in_ready), 128'(0));
    cyc(); lsu_ready = 1'b1;
    @(negedge clk);
    check_eq("full_hold_count", 128'(count), 128'(8));
    for (int d = 1; d <= 8; d++) begin
      cyc(); @(negedge clk);
      check_eq("drain_count", 128'(count), 128'(8 - d));
      if (d == 1) check_eq("in_ready_at_7", 128'(in_ready), 128'(0));
      if (d == 2) check_eq("in_ready_at_6", 128'(in_ready), 128'(1));
    end

    // base wakeup blocks the head
    cyc(); lsu_ready = 1'b1;
    drive_lane(0, 1'b1, 32'hdead, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 6'd20);
    drive_lane(1, 1'b1, 32'h2000, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd21);
    push_exp(1'b1, 32'h1000, 6'd20); push_exp(1'b1, 32'h2000, 6'd21);
    cyc(); @(negedge clk);
    check_eq("wk_count", 128'(count), 128'(2));
    check_eq("wk_blocked0", 128'(lsu_valid), 128'(0));
    cyc(); @(negedge clk);
    check_eq("wk_blocked1", 128'(lsu_valid), 128'(0));
    cyc(); cdb_valid = 2'b01; cdb_tag[0] = 6'd12; cdb_value[0] = 32'h1000;
    @(negedge clk);
`ifdef MEMQ_CDB_BYPASS_EN
    check_eq("wk_bcast_valid", 128'(lsu_valid), 128'(1));
    check_eq("wk_bcast_addr", 128'(lsu_base_addr), 128'(32'h1000));
    cyc(); @(negedge clk);
    check_eq("wk_next_rob", 128'(lsu_rob_idx), 128'(21));
`else
    check_eq("wk_bcast_valid", 128'(lsu_valid), 128'(0));
    cyc(); @(negedge clk);
    check_eq("wk_issue_valid", 128'(lsu_valid), 128'(1));
    check_eq("wk_issue_addr", 128'(lsu_base_addr), 128'(32'h1000));
    check_eq("wk_issue_rob", 128'(lsu_rob_idx), 128'(20));
    cyc(); @(negedge clk);
    check_eq("wk_next_rob", 128'(lsu_rob_idx), 128'(21));
`endif
    cyc(); cyc(); @(negedge clk);
    check_eq("wk_empty", 128'(count), 128'(0));

    // late store data, both CDB ports matching (port 1 wins)
    cyc(); lsu_ready = 1'b0;
    drive_lane(0, 1'b0, 32'h3000, 6'd0, 1'b1, 32'h5555, 6'd20, 1'b0, 6'd30);
    push_exp(1'b0, 32'h3000, 6'd30);
    cyc(); @(negedge clk);
    check_eq("st_valid", 128'(lsu_valid), 128'(1));
    check_eq("st_is_load", 128'(lsu_is_load), 128'(0));
    check_eq("st_sdr_before", 128'(lsu_store_data_ready), 128'(0));
    cyc(); cdb_valid = 2'b11; cdb_tag[0] = 6'd20; cdb_tag[1] = 6'd20;
    cdb_value[0] = 32'haaaa; cdb_value[1] = 32'hbbbb;
    @(negedge clk);
`ifdef MEMQ_CDB_BYPASS_EN
    check_eq("st_sdr_bcast", 128'(lsu_store_data_ready), 128'(1));
    check_eq("st_sdv_bcast", 128'(lsu_store_data_val), 128'(32'hbbbb));
`else
    check_eq("st_sdr_bcast", 128'(lsu_store_data_ready), 128'(0));
`endif
    cyc(); @(negedge clk);
    check_eq("st_sdr_after", 128'(lsu_store_data_ready), 128'(1));
    check_eq("st_sdv_after", 128'(lsu_store_data_val), 128'(32'hbbbb));
    check_eq("st_hold_valid", 128'(lsu_valid), 128'(1));
    cyc(); lsu_ready = 1'b1;
    cyc(); @(negedge clk);
    check_eq("st_empty", 128'(count), 128'(0));

    // capture at enqueue from same-cycle CDB
    cyc(); lsu_ready = 1'b0;
    drive_lane(0, 1'b1, 32'hdead, 6'd7, 1'b0, 32'd0, 6'd0, 1'b1, 6'd50);
    drive_lane(1, 1'b0, 32'h51, 6'd0, 1'b1, 32'd0, 6'd9, 1'b0, 6'd51);
    cdb_valid = 2'b11; cdb_tag[0] = 6'd7; cdb_value[0] = 32'h7777;
    cdb_tag[1] = 6'd9; cdb_value[1] = 32'h9999;
    push_exp(1'b1, 32'h7777, 6'd50); push_exp(1'b0, 32'h51, 6'd51);
    cyc(); @(negedge clk);
    check_eq("cap_valid", 128'(lsu_valid), 128'(1));
    check_eq("cap_base", 128'(lsu_base_addr), 128'(32'h7777));
    cyc(); lsu_ready = 1'b1;
    cyc(); @(negedge clk);
    check_eq("cap_sdr", 128'(lsu_store_data_ready), 128'(1));
    check_eq("cap_sdv", 128'(lsu_store_data_val), 128'(32'h9999));
    cyc(); @(negedge clk);
    check_eq("cap_empty", 128'(count), 128'(0));

    // flush mid-stream
    cyc(); lsu_ready = 1'b0;
    drive_lane(0, 1'b1, 32'h600, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd60);
    drive_lane(1, 1'b1, 32'h610, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd61);
    cyc();
    drive_lane(0, 1'b1, 32'h620, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd62);
    drive_lane(1, 1'b1, 32'h630, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd63);
    cyc();
    drive_lane(0, 1'b1, 32'h640, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd0);
    cyc(); flush = 1'b1;
    drive_lane(0, 1'b1, 32'h700, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd0);
    drive_lane(1, 1'b1, 32'h710, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'd1);
    @(negedge clk);
    check_eq("fl_count_before", 128'(count), 128'(5));
    check_eq("fl_valid_forced", 128'(lsu_valid), 128'(0));
    cyc(); @(negedge clk);
    check_eq("fl_count_after", 128'(count), 128'(0));
    check_eq("fl_valid_after", 128'(lsu_valid), 128'(0));
    check_eq("fl_in_ready", 128'(in_ready), 128'(1));

    // lane-1-only enqueue across the pointer wrap
    cyc(); lsu_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      drive_lane(1, 1'b1, 32'h4000 + 32'(k), 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 6'(40 + k));
      in_opcode[0] = 8'hff; in_base_val[0] = 32'hffff_ffff;
      push_exp(1'b1, 32'h4000 + 32'(k), 6'(40 + k));
      @(negedge clk);
      check_eq("l1_count", 128'(count), 128'(k == 0 ? 0 : 1));
    end
    cyc(); cyc(); @(negedge clk);
    check_eq("l1_empty", 128'(count), 128'(0));

    // randomized phase: all bases ready, model tracks occupancy
    mcount = 0;
    rob_ctr = 6'd0;
    for (int c = 0; c < 60; c++) begin
      cyc();
      v = 2'($urandom_range(0, 3));
      lsu_ready = 1'($urandom_range(0, 1));
      acc = (mcount <= DEPTH - 2) && (v != 2'b00);
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
          ld = 1'($urandom_range(0, 1));
          b = $urandom();
          drive_lane(l, ld, b, 6'd0, 1'b1, $urandom(), 6'd0, 1'b1, rob_ctr);
          if (acc) push_exp(ld, b, rob_ctr);
          rob_ctr = rob_ctr + 6'd1;
        end
      end
      deq_m = (mcount != 0) && lsu_ready;
      @(negedge clk);
      check_eq("rnd_count", 128'(count), 128'(mcount));
      check_eq("rnd_in_ready", 128'(in_ready), 128'(mcount <= DEPTH - 2));
      check_eq("rnd_valid", 128'(lsu_valid), 128'(mcount != 0));
      mcount = mcount + (acc ? (int'(v[0]) + int'(v[1])) : 0) - int'(deq_m);
    end
    cyc(); lsu_ready = 1'b1;
    repeat (10) cyc();
    @(negedge clk);
    check_eq("final_count", 128'(count), 128'(0));
    check_eq("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_op_sequencer.md
# mem_op_sequencer

Buffers memory operations (load/store/CAS) from the 2-wide dispatch stage and issues them to the LSU one per cycle, in program order. It sits between dispatch and the LSU. Dispatch no longer has to stall when both lanes carry memory ops in the same cycle. Queued entries snoop the CDB so that a late base-address or store-data operand is captured before issue.

## Interface
Parameters:
- `DEPTH`, 8: number of queue entries; power of two, ≥2.
- `XLEN`, 32: operand width.
- `PHYS_W`, 6: physical tag width.
- `ROB_W`, 6: ROB index width.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, [1:0]: per-lane memory op present. Lane 0 is older.
- `in_is_load`, input, [1:0]: 1 = load or CAS, 0 = store.
- `in_opcode`, input, [1:0][7:0]: LSU opcode.
- `in_base_val`, input, [1:0][XLEN-1:0]: base operand value.
- `in_base_tag`, input, [1:0][PHYS_W-1:0]: base operand tag.
- `in_base_ready`, input, [1:0]: base operand valid.
- `in_offset`, input, [1:0][XLEN-1:0]: immediate offset.
- `in_data_val`, input, [1:0][XLEN-1:0]: store data value.
- `in_data_tag`, input, [1:0][PHYS_W-1:0]: store data tag.
- `in_data_ready`, input, [1:0]: store data valid.
- `in_phys_rd`, input, [1:0][PHYS_W-1:0]: destination physical tag.
- `in_rob_idx`, input, [1:0][ROB_W-1:0]: ROB index.
- `in_ready`, output, 1: queue can accept both lanes this cycle.
- `flush`, input, 1: discard all entries.
- `cdb_valid`, input, [1:0]: CDB broadcast valid.
- `cdb_tag`, input, [1:0][PHYS_W-1:0]: CDB broadcast tag.
- `cdb_value`, input, [1:0][XLEN-1:0]: CDB broadcast value.
- `lsu_valid`, output, 1: head entry is offered to the LSU.
- `lsu_ready`, input, 1: LSU accepts the head entry.
- `lsu_is_load`, output, 1: head entry field.
- `lsu_opcode`, output, 8: head entry field.
- `lsu_base_addr`, output, XLEN: head entry field.
- `lsu_offset`, output, XLEN: head entry field.
- `lsu_phys_rd`, output, PHYS_W: head entry field.
- `lsu_rob_idx`, output, ROB_W: head entry field.
- `lsu_store_data_val`, output, XLEN: head entry field.
- `lsu_store_data_ready`, output, 1: head entry field.
- `count`, output, $clog2(DEPTH+1): number of occupied entries.

## Operation
- **Storage:** circular buffer with `head` and `tail` pointers, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- **`in_ready`:** `(DEPTH - count) >= 2`. Computed from the registered count only; a same-cycle dequeue does not raise it.
- **Enqueue:** occurs when `in_ready` is high and at least one `in_valid` bit is set.
  - Valid lanes are written at `tail`, `tail+1` in lane order and compacted: lane 1 alone is written at `tail`.
  - `tail` advances by popcount(`in_valid`).
  - If `in_valid` is asserted while `in_ready` is low, nothing is written. Dispatch must hold the ops.
- **Enqueue capture:** an incoming operand with ready=0 whose tag matches a valid CDB port in the same cycle is written with ready=1 and the CDB value.
- **Wakeup:** each cycle, every occupied entry with base or data ready=0 compares its tag against both CDB ports. On a match it latches the value and sets ready. If both ports match, port 1 wins.
- **Issue:**
  - `lsu_valid = (count != 0) && head.base_ready && !flush`.
  - Store data readiness does not gate issue. It is forwarded on `lsu_store_data_ready`.
  - An entry whose base is not ready blocks the queue (strict in-order).
- **Dequeue:** on `lsu_valid && lsu_ready`, `head` advances by 1.
- **Simultaneous enqueue and dequeue:** `count_next = count + enq_n - deq`.
- **Flush:**
  - In the flush cycle: no enqueue, no dequeue, `lsu_valid` forced to 0.
  - Next cycle: `head = tail = count = 0`, all entry ready bits cleared.
- **Reset:** same end state as flush. In addition, entry storage is zeroed.
  - Outputs after reset: `lsu_valid=0`, `in_ready=1`, `count=0`, all `lsu_*` fields 0.
  - `reset` takes priority over `flush`.

## Timing
- Enqueue in cycle T makes the entry visible at head no earlier than T+1, giving a minimum of 1 cycle in-to-out.
- A wakeup in cycle T is visible on outputs in T+1, unless the bypass macro is compiled in (see Configuration).
- `lsu_*` fields are driven from the head entry register. There is no combinational path from `in_*` to `lsu_*`.
- `lsu_valid` and fields are held stable while `lsu_ready` is low, except for ready bits and values changing through wakeup.
- Full (`count==DEPTH`): `in_ready=0`. `count==DEPTH-1` also gives `in_ready=0`.
- Empty: `lsu_valid=0`, fields show the stale head slot.

## Configuration
- `MEMQ_CDB_BYPASS_EN` defined:
  - When the head's base or data is not ready and its tag matches a valid CDB port this cycle, `lsu_base_addr` or `lsu_store_data_val` and the corresponding ready are forwarded combinationally from the CDB.
  - The head may therefore issue in the broadcast cycle.
- Undefined: outputs come from entry registers only, and the head issues no earlier than the cycle after the broadcast.

## Test plan
- **Reset then dual enqueue:** after reset, `in_valid=2'b11`, loads with rob_idx 3 and 4, base ready, `lsu_ready=1`. Required: `lsu_valid` high in T+1 with rob_idx 3, then rob_idx 4 in T+2, then `count=0`.
- **Fill to full:** DEPTH=8, enqueue 2 per cycle with `lsu_ready=0`. Required: `count` goes 2, 4, 6; `in_ready` falls at 8. A further `in_valid=2'b11` leaves `count` at 8.
- **Base wakeup blocking:** head entry has base_tag 12, not ready, and a younger entry is ready. Required: `lsu_valid=0` until `cdb_valid[0]=1`, `cdb_tag[0]=12`, `cdb_value[0]=0x1000`. Then `lsu_base_addr=0x1000`, issued in T+1 (same cycle with bypass).
- **Store data late:** store with data tag 20 not ready, base ready. Required: issues with `lsu_store_data_ready=0`. A CDB tag 20 arriving while `lsu_ready=0` updates `lsu_store_data_val` and sets ready next cycle.
- **Flush mid-stream:** 5 entries queued, flush asserted with `in_valid=2'b11`. Required: `lsu_valid=0` that cycle, `count=0` the next cycle, and the new ops are not enqueued.
- **Lane-1-only enqueue and wrap:** `in_valid=2'b10` repeated across the pointer wrap. Required: entries are written contiguously and issued in order.
